// File: rtl/ball_motion.sv
// Ball motion stage: erase, step, strobe direction logic, redraw.
// Runs once every SPEED_DIV frame ticks via a draw request/ack handshake.
module ball_motion #(
  parameter int unsigned SPEED_DIV = 2,
  parameter logic [9:0]  X0        = 10'd156,
  parameter logic [9:0]  Y0        = 10'd200
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       x_du,
  input  logic       y_du,
  input  logic [9:0] x_max,
  input  logic [9:0] y_max,
  input  logic [9:0] size,
  input  logic       lose_enable,
  input  logic       draw_ack,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       logic_go,
  output logic       draw_req,
  output logic       erase,
  output logic       ball_lost
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_MOVE,
    S_LOGIC,
    S_SETTLE,
    S_DRAW
  } state_e;

  localparam logic [3:0] DIV_LAST = 4'(SPEED_DIV - 1);

  state_e     state_q, state_d;
  logic [3:0] div_q, div_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;

  logic        tick_hit;
  logic [9:0]  x_lim, y_lim;
  logic [10:0] x_inc, y_inc;
  logic [9:0]  x_step, y_step;
  logic [9:0]  y_bot;
  logic        lose;

  assign tick_hit = frame_tick && (div_q == DIV_LAST);

  // Clamped one-pixel step; landing exactly on 0 / max-size keeps
  // the downstream edge equality compares reliable.
  assign x_lim  = x_max - size;
  assign y_lim  = y_max - size;
  assign x_inc  = {1'b0, x_q} + 11'd1;
  assign y_inc  = {1'b0, y_q} + 11'd1;
  assign x_step = x_du ? ((x_inc > {1'b0, x_lim}) ? x_lim : x_inc[9:0])
                       : ((x_q == 10'd0) ? 10'd0 : x_q - 10'd1);
  assign y_step = y_du ? ((y_inc > {1'b0, y_lim}) ? y_lim : y_inc[9:0])
                       : ((y_q == 10'd0) ? 10'd0 : y_q - 10'd1);
  assign y_bot  = y_q + size;
  assign lose   = lose_enable && y_du && (y_bot == y_max);

  // State, divider and position registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      div_q   <= 4'd0;
      x_q     <= X0;
      y_q     <= Y0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Next-state sequencing; acks and ticks outside their states are ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (tick_hit) state_d = S_ERASE;
      S_ERASE:  if (draw_ack) state_d = S_MOVE;
      S_MOVE:   state_d = S_LOGIC;
      S_LOGIC:  state_d = S_SETTLE;
      S_SETTLE: state_d = S_DRAW;
      S_DRAW:   if (draw_ack) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Divider counts only in idle; position changes only on the move exit.
  always_comb begin
    div_d = div_q;
    x_d   = x_q;
    y_d   = y_q;
    if (state_q == S_IDLE && frame_tick) begin
      div_d = tick_hit ? 4'd0 : div_q + 4'd1;
    end
    if (state_q == S_MOVE) begin
      if (lose) begin
        x_d = X0;
        y_d = Y0;
      end else begin
        x_d = x_step;
        y_d = y_step;
      end
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    draw_req  = (state_q == S_ERASE) || (state_q == S_DRAW);
    erase     = (state_q == S_ERASE);
    logic_go  = (state_q == S_LOGIC);
    ball_lost = (state_q == S_MOVE) && lose;
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: handshake, stepping, clamps,
// ball loss, divider behaviour and asynchronous reset mid-draw.
module tb_ball_motion;

  logic       clk = 1'b0;
  logic       resetn;
  logic       frame_tick;
  logic       x_du, y_du;
  logic [9:0] x_max, y_max, size;
  logic       lose_enable;
  logic       draw_ack;
  logic [9:0] x, y;
  logic       logic_go, draw_req, erase, ball_lost;

  int tests = 0;
  int fails = 0;

  logic [9:0] ex, ey, nx, ny;
  int         chg;

  ball_motion #(
    .SPEED_DIV(2),
    .X0(10'd156),
    .Y0(10'd200)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .frame_tick(frame_tick),
    .x_du(x_du),
    .y_du(y_du),
    .x_max(x_max),
    .y_max(y_max),
    .size(size),
    .lose_enable(lose_enable),
    .draw_ack(draw_ack),
    .x(x),
    .y(y),
    .logic_go(logic_go),
    .draw_req(draw_req),
    .erase(erase),
    .ball_lost(ball_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] nxt(input logic [9:0] p, input logic du,
                                     input logic [9:0] mx);
    int lim;
    lim = int'(mx) - int'(size);
    if (du) return (int'(p) + 1 > lim) ? 10'(lim) : p + 10'd1;
    return (p == 10'd0) ? 10'd0 : p - 10'd1;
  endfunction

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic tick2();
    tick();
    tick();
  endtask

  // Entered at a negedge with the DUT in S_ERASE; leaves it in S_IDLE.
  task automatic do_move(input int wt, input logic inj,
                         input logic [9:0] ox, input logic [9:0] oy,
                         input logic [9:0] mx, input logic [9:0] my,
                         input logic lost);
    chk("erase_req", draw_req, 1);
    chk("erase_flag", erase, 1);
    chk("erase_x", x, ox);
    chk("erase_y", y, oy);
    for (int i = 0; i < wt; i++) begin
      frame_tick = inj && (i == 3);
      @(negedge clk);
      frame_tick = 1'b0;
      chk("wait_req", draw_req, 1);
      chk("wait_erase", erase, 1);
      chk("wait_xy", {x, y}, {ox, oy});
    end
    draw_ack = 1'b1;
    @(negedge clk);
    draw_ack = 1'b0;
    chk("move_req", draw_req, 0);
    chk("move_go", logic_go, 0);
    chk("move_lost", ball_lost, lost);
    chk("move_xy_old", {x, y}, {ox, oy});
    @(negedge clk);
    chk("logic_go", logic_go, 1);
    chk("logic_lost", ball_lost, 0);
    chk("logic_xy", {x, y}, {mx, my});
    @(negedge clk);
    chk("settle_go", logic_go, 0);
    chk("settle_req", draw_req, 0);
    @(negedge clk);
    chk("draw_req", draw_req, 1);
    chk("draw_erase", erase, 0);
    chk("draw_xy", {x, y}, {mx, my});
    draw_ack = 1'b1;
    @(negedge clk);
    draw_ack = 1'b0;
    chk("idle_req", draw_req, 0);
  endtask

  initial begin
    resetn = 1'b0;
    frame_tick = 1'b0;
    x_du = 1'b1;
    y_du = 1'b0;
    x_max = 10'd320;
    y_max = 10'd240;
    size = 10'd4;
    lose_enable = 1'b0;
    draw_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_x", x, 156);
    chk("rst_y", y, 200);
    chk("rst_strobes", {logic_go, draw_req, erase, ball_lost}, 0);
    resetn = 1'b1;
    chg = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({x, y} != {10'd156, 10'd200} ||
          {logic_go, draw_req, erase, ball_lost} != 4'b0)
        chg++;
    end
    chk("idle_hold", chg, 0);

    // One tick must not move; the second one starts the sequence.
    tick();
    chk("one_tick", draw_req, 0);
    tick();
    do_move(0, 1'b0, 10'd156, 10'd200, 10'd157, 10'd199, 1'b0);

    // Slow renderer plus a tick during the wait that must be dropped.
    tick2();
    do_move(7, 1'b1, 10'd157, 10'd199, 10'd158, 10'd198, 1'b0);
    tick();
    chk("dropped_tick", draw_req, 0);
    tick();
    do_move(0, 1'b0, 10'd158, 10'd198, 10'd159, 10'd197, 1'b0);

    // Walk y down to the bottom edge, then lose the ball there.
    ex = 10'd159;
    ey = 10'd197;
    y_du = 1'b1;
    for (int i = 0; i < 39; i++) begin
      nx = nxt(ex, 1'b1, x_max);
      ny = nxt(ey, 1'b1, y_max);
      tick2();
      do_move(0, 1'b0, ex, ey, nx, ny, 1'b0);
      ex = nx;
      ey = ny;
    end
    chk("bottom_y", y, 236);
    lose_enable = 1'b1;
    tick2();
    do_move(0, 1'b0, 10'd198, 10'd236, 10'd156, 10'd200, 1'b1);
    lose_enable = 1'b0;

    // Asynchronous reset while the redraw request is pending.
    y_du = 1'b0;
    tick2();
    draw_ack = 1'b1;
    @(negedge clk);
    draw_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_req", draw_req, 1);
    chk("pre_rst_xy", {x, y}, {10'd157, 10'd199});
    resetn = 1'b0;
    #1;
    chk("rst_draw_req", draw_req, 0);
    chk("rst_draw_xy", {x, y}, {10'd156, 10'd200});
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    tick2();
    do_move(0, 1'b0, 10'd156, 10'd200, 10'd157, 10'd199, 1'b0);

    // Right edge clamp: 315 -> 316 -> 316 with x_max=320, size=4.
    ex = 10'd157;
    ey = 10'd199;
    for (int i = 0; i < 158; i++) begin
      nx = nxt(ex, 1'b1, x_max);
      ny = nxt(ey, 1'b0, y_max);
      tick2();
      do_move(0, 1'b0, ex, ey, nx, ny, 1'b0);
      ex = nx;
      ey = ny;
    end
    chk("at_315", x, 315);
    tick2();
    do_move(0, 1'b0, 10'd315, 10'd41, 10'd316, 10'd40, 1'b0);
    tick2();
    do_move(0, 1'b0, 10'd316, 10'd40, 10'd316, 10'd39, 1'b0);

    // Left and top floors: walk to zero, then one more step.
    x_du = 1'b0;
    ex = 10'd316;
    ey = 10'd39;
    for (int i = 0; i < 316; i++) begin
      nx = nxt(ex, 1'b0, x_max);
      ny = nxt(ey, 1'b0, y_max);
      tick2();
      do_move(0, 1'b0, ex, ey, nx, ny, 1'b0);
      ex = nx;
      ey = ny;
    end
    chk("at_zero", {x, y}, 20'd0);
    tick2();
    do_move(0, 1'b0, 10'd0, 10'd0, 10'd0, 10'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ball_motion.md
# ball_motion

Ball motion stage directly upstream of the ball direction logic. On every SPEED_DIV-th frame tick it does four things in order:
- erases the ball at its old position through the draw handshake;
- steps the 10-bit ball position one pixel in the commanded direction;
- strobes the direction logic with `logic_go` and gives it one settle cycle;
- redraws the ball at the new position.

It owns the ball `x`/`y` registers consumed by the direction logic and consumes that logic's `x_du`/`y_du`.

## Interface
Parameters:
- SPEED_DIV, 2: frame ticks per one-pixel move; range 1..15.
- X0, 10'd156: ball x after reset and after ball loss.
- Y0, 10'd200: ball y after reset and after ball loss.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset; one clock domain only.
- frame_tick  in  1  one-cycle pulse, once per video frame.
- x_du  in  1  x direction; 1 = increasing x.
- y_du  in  1  y direction; 1 = increasing y.
- x_max  in  10  playfield width in pixels.
- y_max  in  10  playfield height in pixels.
- size  in  10  ball edge length in pixels.
- lose_enable  in  1  when 1, reaching the bottom edge counts as a lost ball.
- draw_ack  in  1  renderer accepted the current request.
- x  out  10  ball left edge.
- y  out  10  ball top edge.
- logic_go  out  1  one-cycle strobe to the direction logic.
- draw_req  out  1  draw request to the renderer.
- erase  out  1  qualifies `draw_req`: 1 = background colour, 0 = ball colour.
- ball_lost  out  1  one-cycle pulse on loss.

## Operation
- Reset values: x=X0, y=Y0, logic_go=0, draw_req=0, erase=0, ball_lost=0, FSM=S_IDLE, divider=0.
- The FSM states are S_IDLE, S_ERASE, S_MOVE, S_LOGIC, S_SETTLE and S_DRAW.
- S_IDLE:
  - A frame_tick with divider==SPEED_DIV-1 clears the divider and goes to S_ERASE.
  - Any other frame_tick increments the divider.
- S_ERASE: draw_req=1, erase=1. On draw_ack sampled high, go to S_MOVE.
- S_MOVE: one cycle; x and y are updated at the exit edge.
  - x: if x_du, x ← min(x+1, x_max−size); else x ← (x==0) ? 0 : x−1.
  - y: the same rule applied with y_du and y_max.
  - Loss: if lose_enable and y_du and (y+size)==y_max at entry, then x←X0, y←Y0 and ball_lost=1 in this cycle.
  - The clamp guarantees that positions land exactly on 0 and max−size, so the downstream equality compares always hit.
- S_LOGIC: logic_go=1 for exactly one cycle. The downstream direction registers update on this edge.
- S_SETTLE: one cycle with no outputs asserted, so the platform-collision result for the new position is registered downstream.
- S_DRAW: draw_req=1, erase=0. On draw_ack, go to S_IDLE.
- Handshake rules:
  - draw_req rises on entry to S_ERASE or S_DRAW and stays high until draw_ack is sampled high.
  - draw_req is low in the cycle after the ack.
  - x, y and erase are stable for the whole time draw_req is high.
  - draw_ack seen outside S_ERASE/S_DRAW is ignored.
- frame_tick outside S_IDLE is dropped: it is neither counted nor queued.
- Arithmetic is unsigned 10-bit. max−size is computed at 10 bits. Configurations with size ≥ x_max or size ≥ y_max are illegal and have no defined behaviour.

## Timing
- Qualifying frame_tick at edge N: draw_req (erase=1) is high from cycle N+1.
- draw_ack at edge A in S_ERASE: S_MOVE runs in cycle A+1, new x/y are visible from A+2, logic_go is high in A+2, S_SETTLE is A+3, and draw_req (erase=0) is high from A+4.
- Minimum move period with a zero-wait renderer: 6 cycles from tick to return to S_IDLE.
- Asserting resetn low at any point, including mid-handshake, clears all state and outputs immediately. Position returns to X0/Y0 and no redraw is issued for the old position.

## Test plan
- Reset with X0=156, Y0=200, then release: x=156, y=200, all strobes 0. Hold with no ticks for 100 cycles and no output changes.
- SPEED_DIV=2, x_du=1, y_du=0, immediate ack: two ticks give one erase (x=156), then x=157, y=199, one logic_go pulse, then a draw at (157,199). A single tick gives no move.
- x_max=320, size=4, x=315, x_du=1: the move gives x=316; a further move with x_du still 1 leaves x at 316 (clamp). With x=0, x_du=0, x stays 0.
- draw_ack delayed 7 cycles in S_ERASE:
  - draw_req stays high for 8 cycles with erase=1 and x/y unchanged;
  - a frame_tick injected mid-wait does not advance the divider.
- lose_enable=1, y_max=240, size=4, y=236, y_du=1: ball_lost pulses for 1 cycle, and the position becomes (156,200) before the S_DRAW request.
- resetn pulsed low while draw_req=1 in S_DRAW: draw_req=0 immediately and position=(X0,Y0). The next tick sequence completes normally.
